// File: rtl/mc14500b_run_ctrl.sv
// Run/step/halt sequencer for the MC14500B demo core: issues a one-CLK
// instruction enable, holds the core in reset after start-up, counts cycles.
module mc14500b_run_ctrl #(
  parameter int unsigned DIV          = 524288,
  parameter int unsigned RST_CYCLES   = 4,
  parameter bit          HALT_ON_FLG0 = 1'b1,
  parameter bit          STOP_ON_FLGF = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             run_toggle,
  input  logic             step_req,
  input  logic             restart,
  input  logic             flg0,
  input  logic             flgf,
  output logic             core_rst,
  output logic             core_ce,
  output logic             running,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic [7:0]       loop_count
);

  localparam int unsigned DIV_W = 24;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 32'd1);
  localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  state_t           state_r, state_nxt_s;
  logic [DIV_W-1:0] div_r, div_nxt_s;
  logic [7:0]       rst_cnt_r, rst_cnt_nxt_s;
  logic             core_ce_r, core_ce_nxt_s;
  logic             core_rst_r, core_rst_nxt_s;
  logic             running_r, running_nxt_s;
  logic [CNT_W-1:0] instr_count_r, instr_count_nxt_s;
  logic [7:0]       loop_count_r, loop_count_nxt_s;
  logic             flag_halt_s;

  // Flags only matter in the cycle the core actually executes an instruction.
  always_comb begin
    flag_halt_s = core_ce_r & ((flg0 & HALT_ON_FLG0) | (flgf & STOP_ON_FLGF));
  end

  // Next-state, divider, counters and registered-output precursors.
  always_comb begin
    state_nxt_s       = state_r;
    div_nxt_s         = div_r;
    rst_cnt_nxt_s     = rst_cnt_r;
    core_ce_nxt_s     = 1'b0;
    instr_count_nxt_s = instr_count_r;
    loop_count_nxt_s  = loop_count_r;

    if (core_ce_r) begin
      instr_count_nxt_s = instr_count_r + CNT_W'(1);
    end else begin
      instr_count_nxt_s = instr_count_r;
    end
    if (core_ce_r && flgf) begin
      loop_count_nxt_s = sat_inc8(loop_count_r);
    end else begin
      loop_count_nxt_s = loop_count_r;
    end

    if (restart) begin
      state_nxt_s       = ST_INIT;
      rst_cnt_nxt_s     = 8'd0;
      div_nxt_s         = '0;
      instr_count_nxt_s = '0;
      loop_count_nxt_s  = 8'd0;
    end else begin
      case (state_r)
        ST_INIT: begin
          div_nxt_s = '0;
          if (rst_cnt_r == RST_LAST) begin
            state_nxt_s   = ST_HALT;
            rst_cnt_nxt_s = 8'd0;
          end else begin
            rst_cnt_nxt_s = rst_cnt_r + 8'd1;
          end
        end
        ST_HALT: begin
          div_nxt_s = '0;
          if (run_toggle) begin
            state_nxt_s = ST_RUN;
          end else if (step_req) begin
            state_nxt_s   = ST_STEP;
            core_ce_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        ST_STEP: begin
          div_nxt_s   = '0;
          state_nxt_s = ST_HALT;
        end
        ST_RUN: begin
          // Terminal count arms the enable for the following cycle, so a
          // halt or restart in the terminal cycle suppresses the pulse.
          if (run_toggle || flag_halt_s) begin
            state_nxt_s = ST_HALT;
            div_nxt_s   = '0;
          end else if (div_r == DIV_LAST) begin
            div_nxt_s     = '0;
            core_ce_nxt_s = 1'b1;
          end else begin
            div_nxt_s = div_r + DIV_W'(1);
          end
        end
        default: begin
          state_nxt_s   = ST_INIT;
          rst_cnt_nxt_s = 8'd0;
          div_nxt_s     = '0;
        end
      endcase
    end

    core_rst_nxt_s = (state_nxt_s == ST_INIT);
    running_nxt_s  = (state_nxt_s == ST_RUN);
  end

  // State, divider, counters and all outputs are registered here.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_INIT;
      div_r         <= '0;
      rst_cnt_r     <= 8'd0;
      core_ce_r     <= 1'b0;
      core_rst_r    <= 1'b1;
      running_r     <= 1'b0;
      instr_count_r <= '0;
      loop_count_r  <= 8'd0;
    end else begin
      state_r       <= state_nxt_s;
      div_r         <= div_nxt_s;
      rst_cnt_r     <= rst_cnt_nxt_s;
      core_ce_r     <= core_ce_nxt_s;
      core_rst_r    <= core_rst_nxt_s;
      running_r     <= running_nxt_s;
      instr_count_r <= instr_count_nxt_s;
      loop_count_r  <= loop_count_nxt_s;
    end
  end

  assign core_rst    = core_rst_r;
  assign core_ce     = core_ce_r;
  assign running     = running_r;
  assign state       = state_r;
  assign instr_count = instr_count_r;
  assign loop_count  = loop_count_r;

endmodule

// File: tb/tb_mc14500b_run_ctrl.sv
// Scoreboard bench for mc14500b_run_ctrl: two instances with different
// parameters share stimulus and are compared every cycle against a model.
module tb_mc14500b_run_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_toggle = 1'b0, step_req = 1'b0, restart = 1'b0, flg0 = 1'b0, flgf = 1'b0;

  logic       a_core_rst, a_core_ce, a_running;
  logic [1:0] a_state;
  logic [15:0] a_instr;
  logic [7:0] a_loop;
  logic       b_core_rst, b_core_ce, b_running;
  logic [1:0] b_state;
  logic [3:0] b_instr;
  logic [7:0] b_loop;

  always #5 clk = ~clk;

  mc14500b_run_ctrl #(.DIV(8), .RST_CYCLES(4), .HALT_ON_FLG0(1'b1),
                      .STOP_ON_FLGF(1'b0), .CNT_W(16)) dut_a (
    .CLK(clk), .rst_n(rst_n), .run_toggle(run_toggle), .step_req(step_req),
    .restart(restart), .flg0(flg0), .flgf(flgf), .core_rst(a_core_rst),
    .core_ce(a_core_ce), .running(a_running), .state(a_state),
    .instr_count(a_instr), .loop_count(a_loop));

  mc14500b_run_ctrl #(.DIV(5), .RST_CYCLES(3), .HALT_ON_FLG0(1'b0),
                      .STOP_ON_FLGF(1'b1), .CNT_W(4)) dut_b (
    .CLK(clk), .rst_n(rst_n), .run_toggle(run_toggle), .step_req(step_req),
    .restart(restart), .flg0(flg0), .flgf(flgf), .core_rst(b_core_rst),
    .core_ce(b_core_ce), .running(b_running), .state(b_state),
    .instr_count(b_instr), .loop_count(b_loop));

  // Reference model: mode 0 INIT, 1 HALT, 2 RUN, 3 STEP; run_t = cycles since entering RUN.
  typedef struct {
    int mode;
    int rst_left;
    int run_t;
    bit ce;
    int icnt;
    int lcnt;
  } mdl_t;

  typedef struct {
    int id;
    mdl_t m;
  } exp_t;

  exp_t q[$];
  mdl_t ma, mb;
  int n_checks = 0;
  int n_fail = 0;

  function automatic mdl_t mdl_reset(input int rstc);
    mdl_t m;
    m.mode = 0; m.rst_left = rstc; m.run_t = 0; m.ce = 1'b0; m.icnt = 0; m.lcnt = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int div, input int rstc,
                                    input bit h0, input bit sf, input int cw,
                                    input bit rt, input bit sr, input bit rs,
                                    input bit f0, input bit ff);
    mdl_t n;
    bit forced;
    n = m;
    n.ce = 1'b0;
    if (rs) return mdl_reset(rstc);
    if (m.ce) begin
      n.icnt = (m.icnt + 1) % (1 << cw);
      if (ff && m.lcnt < 255) n.lcnt = m.lcnt + 1;
    end
    forced = m.ce && ((f0 && h0) || (ff && sf));
    case (m.mode)
      0: begin
        n.rst_left = m.rst_left - 1;
        if (n.rst_left == 0) n.mode = 1;
      end
      1: begin
        if (rt) begin
          n.mode = 2; n.run_t = 0;
        end else if (sr) begin
          n.mode = 3; n.ce = 1'b1;
        end
      end
      2: begin
        if (rt || forced) begin
          n.mode = 1;
        end else begin
          n.run_t = m.run_t + 1;
          n.ce = ((n.run_t % div) == 0);
        end
      end
      3: n.mode = 1;
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: apply reset/inputs, queue this cycle's expectation, advance the model.
  task automatic cyc(input bit rv, input bit rt, input bit sr, input bit rs,
                     input bit f0, input bit ff);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rv;
    if (!rv) begin
      ma = mdl_reset(4);
      mb = mdl_reset(3);
    end
    e.id = 0; e.m = ma; q.push_back(e);
    e.id = 1; e.m = mb; q.push_back(e);
    run_toggle = rt; step_req = sr; restart = rs; flg0 = f0; flgf = ff;
    if (rv) begin
      ma = mdl_step(ma, 8, 4, 1'b1, 1'b0, 16, rt, sr, rs, f0, ff);
      mb = mdl_step(mb, 5, 3, 1'b0, 1'b1, 4, rt, sr, rs, f0, ff);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.id == 0) begin
        chk("a_core_rst", int'(a_core_rst), int'(e.m.mode == 0));
        chk("a_core_ce", int'(a_core_ce), int'(e.m.ce));
        chk("a_running", int'(a_running), int'(e.m.mode == 2));
        chk("a_state", int'(a_state), e.m.mode);
        chk("a_instr_count", int'(a_instr), e.m.icnt);
        chk("a_loop_count", int'(a_loop), e.m.lcnt);
      end else begin
        chk("b_core_rst", int'(b_core_rst), int'(e.m.mode == 0));
        chk("b_core_ce", int'(b_core_ce), int'(e.m.ce));
        chk("b_running", int'(b_running), int'(e.m.mode == 2));
        chk("b_state", int'(b_state), e.m.mode);
        chk("b_instr_count", int'(b_instr), e.m.icnt);
        chk("b_loop_count", int'(b_loop), e.m.lcnt);
      end
    end
  end

  initial begin
    ma = mdl_reset(4);
    mb = mdl_reset(3);

    // Power-on reset and release.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("reset_halt_state", int'(a_state), 1);
    chk("reset_core_rst_low", int'(a_core_rst), 0);
    chk("reset_instr_zero", int'(a_instr), 0);

    // Three single steps from HALT.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(9);
    end
    chk("step_instr_3", int'(a_instr), 3);

    // RUN for 43 cycles, then toggle back to HALT: five pulses for DIV = 8.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(43);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    chk("run_instr_8", int'(a_instr), 8);
    chk("run_back_halt", int'(a_state), 1);

    // flg0 high around the third pulse: A halts, B keeps running.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(17);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    chk("flg0_halt_state", int'(a_state), 1);
    chk("flg0_instr_11", int'(a_instr), 11);
    chk("flg0_ignored_b", int'(b_running), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    chk("restart_instr_clear", int'(a_instr), 0);

    // flgf on every pulse: A saturates loop_count, B stops at the first flgf.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2420; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flgf_saturate_a", int'(a_loop), 255);
    chk("flgf_stop_b_loop", int'(b_loop), 1);
    chk("flgf_stop_b_state", int'(b_state), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Restart on A's terminal-count cycle, then simultaneous step_req + run_toggle.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(7);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("restart_tc_ce_low", int'(a_core_ce), 0);
    chk("restart_tc_core_rst", int'(a_core_rst), 1);
    chk("restart_tc_state_init", int'(a_state), 0);
    idle(6);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("toggle_beats_step_a", int'(a_state), 2);
    chk("toggle_beats_step_b", int'(b_state), 2);

    // Random operation with occasional asynchronous reset mid-run.
    for (int i = 0; i < 4000; i++) begin
      bit rv, rt, sr, rs, f0, ff;
      rv = ($urandom_range(0, 499) != 0);
      rt = ($urandom_range(0, 39) == 0);
      sr = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 199) == 0);
      f0 = ($urandom_range(0, 3) == 0);
      ff = ($urandom_range(0, 2) == 0);
      cyc(rv, rt, sr, rs, f0, ff);
    end

    idle(3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
